ex_stage: RTL and testbench

- Execute pipeline stage of the RISC-V core. It sits between the decode stage (upstream) and the memory stage (downstream).
- Selects ALU operands, including immediate/PC selection and EX/MEM and MEM/WB forwarding. Drives the combinational alu and registers the result into the EX/MEM pipeline register.
- Uses a valid/ready handshake on both sides, plus a flush input for branch/trap squash.

---
 rtl/lib_pkg.sv | 40 ++++
 rtl/alu.sv | 49 ++++
 rtl/fwd_mux.sv | 44 ++++
 rtl/ex_stage.sv | 164 ++++++++++++++++
 tb/tb_ex_stage.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lib_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lib_pkg
// Description : Shared types and constants for the core datapath. It defines
//               the ALU operation encoding, the operand-select encodings used
//               by the execute stage, and the hard-wired zero register index.
// Revision    : 1.0 - initial release
// ============================================================================
package lib_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_type_t;

    typedef enum logic [1:0] {
        OP0_RS1  = 2'd0,
        OP0_PC   = 2'd1,
        OP0_ZERO = 2'd2
    } op0_sel_t;

    typedef enum logic [1:0] {
        OP1_RS2  = 2'd0,
        OP1_IMM  = 2'd1,
        OP1_FOUR = 2'd2
    } op1_sel_t;

    // Index of the architectural zero register. It is never forwarded.
    localparam int unsigned REG_ZERO = 0;

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : Combinational integer ALU. All results are WIDTH wide and wrap
//               modulo 2^WIDTH. Shift amounts use the low 5 bits of i_op1.
// Ports       : i_alu_type - operation select
//               i_op0      - first operand
//               i_op1      - second operand / shift amount
//               o_result   - operation result
// Revision    : 1.0 - initial release
// ============================================================================
module alu
    import lib_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  alu_type_t          i_alu_type,
    input  logic [WIDTH-1:0]   i_op0,
    input  logic [WIDTH-1:0]   i_op1,
    output logic [WIDTH-1:0]   o_result
);

    logic [4:0] w_shamt;
    logic       w_lt_signed;
    logic       w_lt_unsigned;

    assign w_shamt       = i_op1[4:0];
    assign w_lt_signed   = ($signed(i_op0) < $signed(i_op1));
    assign w_lt_unsigned = (i_op0 < i_op1);

    always_comb begin
        o_result = '0;
        case (i_alu_type)
            ALU_ADD:  o_result = i_op0 + i_op1;
            ALU_SUB:  o_result = i_op0 - i_op1;
            ALU_SLL:  o_result = i_op0 << w_shamt;
            ALU_SLT:  o_result = {{(WIDTH-1){1'b0}}, w_lt_signed};
            ALU_SLTU: o_result = {{(WIDTH-1){1'b0}}, w_lt_unsigned};
            ALU_XOR:  o_result = i_op0 ^ i_op1;
            ALU_SRL:  o_result = i_op0 >> w_shamt;
            ALU_SRA:  o_result = $unsigned($signed(i_op0) >>> w_shamt);
            ALU_OR:   o_result = i_op0 | i_op1;
            ALU_AND:  o_result = i_op0 & i_op1;
            default:  o_result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fwd_mux.sv
`default_nettype none
// ============================================================================
// Module      : fwd_mux
// Description : Resolves one source operand against in-flight writers. The
//               EX/MEM result wins over the MEM/WB write, which wins over the
//               register-file value. The zero register is never forwarded.
// Ports       : i_src_addr / i_src_val     - operand index and RF read value
//               i_ex_fwd_en                - EX/MEM holds a valid writer
//               i_ex_rd_addr / i_ex_result - EX/MEM destination and result
//               i_wb_valid / i_wb_rd_addr / i_wb_data - MEM/WB write
//               o_val                      - resolved operand value
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_mux
    import lib_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] i_src_addr,
    input  logic [WIDTH-1:0]      i_src_val,
    input  logic                  i_ex_fwd_en,
    input  logic [REG_ADDR_W-1:0] i_ex_rd_addr,
    input  logic [WIDTH-1:0]      i_ex_result,
    input  logic                  i_wb_valid,
    input  logic [REG_ADDR_W-1:0] i_wb_rd_addr,
    input  logic [WIDTH-1:0]      i_wb_data,
    output logic [WIDTH-1:0]      o_val
);

    logic w_nonzero;
    logic w_ex_hit;
    logic w_wb_hit;

    assign w_nonzero = (i_src_addr != REG_ADDR_W'(REG_ZERO));
    assign w_ex_hit  = i_ex_fwd_en && (i_ex_rd_addr == i_src_addr) && w_nonzero;
    assign w_wb_hit  = i_wb_valid  && (i_wb_rd_addr == i_src_addr) && w_nonzero;

    assign o_val = w_ex_hit ? i_ex_result :
                   w_wb_hit ? i_wb_data   :
                              i_src_val;

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage
// Description : Execute pipeline stage. Forwards source operands, selects ALU
//               inputs, computes the result and holds it in the EX/MEM
//               register behind a valid/ready handshake with flush support.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               flush                    - squash EX/MEM and drop the input
//               in_valid / in_ready      - decode-side handshake
//               in_*                     - decoded instruction fields
//               wb_valid/wb_rd_addr/wb_data - MEM/WB write for forwarding
//               out_valid / out_ready    - memory-side handshake
//               out_result, out_store_data, out_rd_addr, out_reg_write
//                                        - EX/MEM register contents
// Revision    : 1.0 - initial release
// ============================================================================
module ex_stage
    import lib_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  alu_type_t             in_alu_type,
    input  logic [REG_ADDR_W-1:0] in_rs1_addr,
    input  logic [REG_ADDR_W-1:0] in_rs2_addr,
    input  logic [WIDTH-1:0]      in_rs1_val,
    input  logic [WIDTH-1:0]      in_rs2_val,
    input  logic [WIDTH-1:0]      in_imm,
    input  logic [WIDTH-1:0]      in_pc,
    input  op0_sel_t              in_op0_sel,
    input  op1_sel_t              in_op1_sel,
    input  logic [REG_ADDR_W-1:0] in_rd_addr,
    input  logic                  in_reg_write,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr,
    input  logic [WIDTH-1:0]      wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_result,
    output logic [WIDTH-1:0]      out_store_data,
    output logic [REG_ADDR_W-1:0] out_rd_addr,
    output logic                  out_reg_write
);

    localparam logic [WIDTH-1:0] c_four = WIDTH'(4);

    logic                  r_valid;
    logic [WIDTH-1:0]      r_result;
    logic [WIDTH-1:0]      r_store_data;
    logic [REG_ADDR_W-1:0] r_rd_addr;
    logic                  r_reg_write;

    logic                  w_accept;
    logic                  w_ex_fwd_en;
    logic                  w_rd_writes;
    logic [WIDTH-1:0]      w_rs1_fwd;
    logic [WIDTH-1:0]      w_rs2_fwd;
    logic [WIDTH-1:0]      w_op0;
    logic [WIDTH-1:0]      w_op1;
    logic [WIDTH-1:0]      w_alu_result;

    // Ready depends only on registered state and downstream ready, so there is
    // no path from in_valid back into in_ready.
    assign in_ready    = !r_valid || out_ready;
    assign w_accept    = in_valid && in_ready && !flush;
    assign w_ex_fwd_en = r_valid && r_reg_write;
    // Writes to x0 are architecturally discarded, so drop the enable here and
    // keep x0 out of any downstream forwarding compare.
    assign w_rd_writes = in_reg_write && (in_rd_addr != REG_ADDR_W'(REG_ZERO));

    fwd_mux #(
        .WIDTH      (WIDTH),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_rs1 (
        .i_src_addr   (in_rs1_addr),
        .i_src_val    (in_rs1_val),
        .i_ex_fwd_en  (w_ex_fwd_en),
        .i_ex_rd_addr (r_rd_addr),
        .i_ex_result  (r_result),
        .i_wb_valid   (wb_valid),
        .i_wb_rd_addr (wb_rd_addr),
        .i_wb_data    (wb_data),
        .o_val        (w_rs1_fwd)
    );

    fwd_mux #(
        .WIDTH      (WIDTH),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_rs2 (
        .i_src_addr   (in_rs2_addr),
        .i_src_val    (in_rs2_val),
        .i_ex_fwd_en  (w_ex_fwd_en),
        .i_ex_rd_addr (r_rd_addr),
        .i_ex_result  (r_result),
        .i_wb_valid   (wb_valid),
        .i_wb_rd_addr (wb_rd_addr),
        .i_wb_data    (wb_data),
        .o_val        (w_rs2_fwd)
    );

    always_comb begin
        w_op0 = '0;
        case (in_op0_sel)
            OP0_RS1:  w_op0 = w_rs1_fwd;
            OP0_PC:   w_op0 = in_pc;
            OP0_ZERO: w_op0 = '0;
            default:  w_op0 = '0;
        endcase
    end

    always_comb begin
        w_op1 = '0;
        case (in_op1_sel)
            OP1_RS2:  w_op1 = w_rs2_fwd;
            OP1_IMM:  w_op1 = in_imm;
            OP1_FOUR: w_op1 = c_four;
            default:  w_op1 = '0;
        endcase
    end

    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .i_alu_type (in_alu_type),
        .i_op0      (w_op0),
        .i_op1      (w_op1),
        .o_result   (w_alu_result)
    );

    // Flush only clears valid; data fields keep their last values so nothing
    // downstream sees X when out_valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_result     <= '0;
            r_store_data <= '0;
            r_rd_addr    <= '0;
            r_reg_write  <= 1'b0;
        end else if (flush) begin
            r_valid      <= 1'b0;
        end else if (w_accept) begin
            r_valid      <= 1'b1;
            r_result     <= w_alu_result;
            r_store_data <= w_rs2_fwd;
            r_rd_addr    <= in_rd_addr;
            r_reg_write  <= w_rd_writes;
        end else if (out_ready) begin
            r_valid      <= 1'b0;
        end
    end

    assign out_valid      = r_valid;
    assign out_result     = r_result;
    assign out_store_data = r_store_data;
    assign out_rd_addr    = r_rd_addr;
    assign out_reg_write  = r_reg_write;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_stage
// Description : Self-checking bench for ex_stage. A reference model predicts
//               each accepted instruction's EX/MEM contents and queues them;
//               the head of the queue is compared whenever out_valid is high
//               and retired on each downstream handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_stage;
    import lib_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    alu_type_t   in_alu_type;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr, wb_rd_addr, out_rd_addr;
    logic [31:0] in_rs1_val, in_rs2_val, in_imm, in_pc, wb_data;
    op0_sel_t    in_op0_sel;
    op1_sel_t    in_op1_sel;
    logic        in_reg_write, wb_valid, out_valid, out_ready, out_reg_write;
    logic [31:0] out_result, out_store_data;

    always #5 clk = ~clk;

    ex_stage #(.WIDTH(32), .REG_ADDR_W(5)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_alu_type(in_alu_type),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .in_imm(in_imm), .in_pc(in_pc),
        .in_op0_sel(in_op0_sel), .in_op1_sel(in_op1_sel),
        .in_rd_addr(in_rd_addr), .in_reg_write(in_reg_write),
        .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_store_data(out_store_data),
        .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write)
    );

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] st;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;

    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model of the EX/MEM register state.
    logic        m_valid = 1'b0;
    logic        m_rw    = 1'b0;
    logic [4:0]  m_rd    = '0;
    logic [31:0] m_res   = '0;
    logic        m_zero  = 1'b0;
    logic        m_live  = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] alu_model(input alu_type_t t, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (t)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << sh;
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> sh;
            ALU_SRA:  return 32'($signed(a) >>> sh);
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] fwd_model(input logic [4:0] a, input logic [31:0] v);
        if (a != 5'd0 && m_valid && m_rw && m_rd == a) return m_res;
        if (a != 5'd0 && wb_valid && wb_rd_addr == a)  return wb_data;
        return v;
    endfunction

    // One clock: check outputs at the falling edge, advance the model for the
    // coming rising edge, then return 1 ns after that edge.
    task automatic tick();
        exp_t        e;
        logic [31:0] f1, f2, o0, o1;
        logic        rdy, acc, drain;
        @(negedge clk);
        if (m_live) begin
            check("in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || out_ready)});
            check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            if (m_zero) begin
                check("rst_result", out_result, 32'd0);
                check("rst_store", out_store_data, 32'd0);
                check("rst_rd", {27'd0, out_rd_addr}, 32'd0);
                check("rst_rw", {31'd0, out_reg_write}, 32'd0);
            end
            if (m_valid) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    check("result", out_result, sb[0].res);
                    check("store_data", out_store_data, sb[0].st);
                    check("rd_addr", {27'd0, out_rd_addr}, {27'd0, sb[0].rd});
                    check("reg_write", {31'd0, out_reg_write}, {31'd0, sb[0].rw});
                end
            end
        end
        rdy   = !m_valid || out_ready;
        acc   = in_valid && rdy && !flush;
        drain = m_valid && out_ready;
        if (rst) begin
            m_valid = 1'b0; m_rw = 1'b0; m_rd = '0; m_res = '0;
            sb.delete();
            m_zero = 1'b1;
        end else begin
            m_zero = 1'b0;
            if (flush) begin
                m_valid = 1'b0;
                sb.delete();
            end else if (acc) begin
                f1 = fwd_model(in_rs1_addr, in_rs1_val);
                f2 = fwd_model(in_rs2_addr, in_rs2_val);
                o0 = (in_op0_sel == OP0_RS1) ? f1 : (in_op0_sel == OP0_PC) ? in_pc : 32'd0;
                o1 = (in_op1_sel == OP1_RS2) ? f2 : (in_op1_sel == OP1_IMM) ? in_imm : 32'd4;
                e.res = alu_model(in_alu_type, o0, o1);
                e.st  = f2;
                e.rd  = in_rd_addr;
                e.rw  = in_reg_write && (in_rd_addr != 5'd0);
                if (drain && sb.size() > 0) void'(sb.pop_front());
                sb.push_back(e);
                m_valid = 1'b1; m_res = e.res; m_rd = e.rd; m_rw = e.rw;
            end else if (drain) begin
                if (sb.size() > 0) void'(sb.pop_front());
                m_valid = 1'b0;
            end
        end
        m_live = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input alu_type_t t, input op0_sel_t s0, input op1_sel_t s1,
                         input logic [4:0] a1, input logic [31:0] v1,
                         input logic [4:0] a2, input logic [31:0] v2,
                         input logic [31:0] imm, input logic [31:0] pc,
                         input logic [4:0] rd, input logic rw);
        in_valid = 1'b1; in_alu_type = t; in_op0_sel = s0; in_op1_sel = s1;
        in_rs1_addr = a1; in_rs1_val = v1; in_rs2_addr = a2; in_rs2_val = v2;
        in_imm = imm; in_pc = pc; in_rd_addr = rd; in_reg_write = rw;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        wb_valid = 1'b0; wb_rd_addr = '0; wb_data = '0;
        issue(ALU_ADD, OP0_RS1, OP1_RS2, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        in_valid = 1'b0;

        // Reset for two cycles, then a basic ADD with an immediate.
        tick(); tick();
        rst = 1'b0;
        issue(ALU_ADD, OP0_RS1, OP1_IMM, 5'd4, 32'd5, 5'd0, 32'd0, 32'd7, 32'd0, 5'd3, 1'b1);
        tick();
        check("basic_add", out_result, 32'd12);
        in_valid = 1'b0;
        tick();

        // Back-to-back EX forwarding; the WB match on x1 must lose.
        issue(ALU_ADD, OP0_RS1, OP1_RS2, 5'd6, 32'd10, 5'd7, 32'd20, 32'd0, 32'd0, 5'd1, 1'b1);
        tick();
        check("fwd_first", out_result, 32'd30);
        issue(ALU_SUB, OP0_RS1, OP1_IMM, 5'd1, 32'd0, 5'd0, 32'd0, 32'd3, 32'd0, 5'd2, 1'b1);
        wb_valid = 1'b1; wb_rd_addr = 5'd1; wb_data = 32'd99;
        tick();
        check("fwd_ex_over_wb", out_result, 32'd27);
        in_valid = 1'b0; wb_valid = 1'b0;
        tick();

        // x0 guard: a write to x0 is never forwarded and its enable is dropped.
        issue(ALU_ADD, OP0_RS1, OP1_IMM, 5'd8, 32'hFFFF_FFFF, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b1);
        tick();
        check("x0_rw", {31'd0, out_reg_write}, 32'd0);
        issue(ALU_ADD, OP0_RS1, OP1_IMM, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd5, 1'b1);
        wb_valid = 1'b1; wb_rd_addr = 5'd0; wb_data = 32'd55;
        tick();
        check("x0_operand", out_result, 32'd0);
        in_valid = 1'b0; wb_valid = 1'b0;
        tick();

        // Backpressure for three cycles with a pending instruction.
        issue(ALU_ADD, OP0_RS1, OP1_IMM, 5'd10, 32'd100, 5'd0, 32'd0, 32'd1, 32'd0, 5'd4, 1'b1);
        tick();
        out_ready = 1'b0;
        issue(ALU_ADD, OP0_RS1, OP1_IMM, 5'd11, 32'd200, 5'd0, 32'd0, 32'd2, 32'd0, 5'd6, 1'b1);
        tick(); tick(); tick();
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        check("stall_result", out_result, 32'd101);
        out_ready = 1'b1;
        tick();
        check("release_result", out_result, 32'd202);
        in_valid = 1'b0;
        tick();

        // Flush with a held instruction and a pending input.
        out_ready = 1'b0;
        issue(ALU_ADD, OP0_RS1, OP1_IMM, 5'd12, 32'd1, 5'd0, 32'd0, 32'd1, 32'd0, 5'd7, 1'b1);
        tick();
        issue(ALU_ADD, OP0_RS1, OP1_IMM, 5'd13, 32'd50, 5'd0, 32'd0, 32'd0, 32'd0, 5'd8, 1'b1);
        flush = 1'b1;
        tick();
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();

        // Flush together with reset gives reset values.
        issue(ALU_ADD, OP0_RS1, OP1_IMM, 5'd14, 32'd9, 5'd0, 32'd0, 32'd9, 32'd0, 5'd9, 1'b1);
        tick();
        rst = 1'b1; flush = 1'b1;
        tick();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        tick();

        // Operand select and wrap cases.
        issue(ALU_ADD, OP0_PC, OP1_FOUR, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 32'h100, 5'd10, 1'b1);
        tick();
        check("pc_plus_four", out_result, 32'h104);
        issue(ALU_ADD, OP0_RS1, OP1_IMM, 5'd15, 32'hFFFF_FFFF, 5'd0, 32'd0, 32'd1, 32'd0, 5'd11, 1'b1);
        tick();
        check("add_wrap", out_result, 32'd0);
        issue(ALU_SRA, OP0_RS1, OP1_RS2, 5'd16, 32'h8000_0000, 5'd17, 32'd33, 32'd0, 32'd0, 5'd12, 1'b1);
        tick();
        check("sra_shamt", out_result, 32'hC000_0000);
        issue(ALU_ADD, OP0_ZERO, OP1_IMM, 5'd0, 32'd0, 5'd0, 32'd0, 32'h1234, 32'd0, 5'd9, 1'b1);
        tick();
        issue(ALU_ADD, OP0_RS1, OP1_IMM, 5'd0, 32'd0, 5'd9, 32'd0, 32'd1, 32'd0, 5'd13, 1'b1);
        tick();
        check("store_fwd", out_store_data, 32'h1234);
        in_valid = 1'b0;
        tick();

        // Random mix with narrow register indices to provoke hazards.
        for (int i = 0; i < 60; i++) begin
            issue(alu_type_t'($urandom_range(0, 9)), op0_sel_t'($urandom_range(0, 2)),
                  op1_sel_t'($urandom_range(0, 2)),
                  5'($urandom_range(0, 3)), $urandom(), 5'($urandom_range(0, 3)), $urandom(),
                  $urandom(), $urandom(), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 15) == 0);
            wb_valid   = 1'($urandom_range(0, 1));
            wb_rd_addr = 5'($urandom_range(0, 3));
            wb_data    = $urandom();
            tick();
        end

        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; wb_valid = 1'b0;
        tick(); tick(); tick();
        check("sb_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
